// File: rtl/perf_readout.sv
// Performance counter read-out: live cycle/instruction counters, snapshot on
// halt / watchdog / host request, framed 16-bit stream. Optional stall counter under PERF_STALL_COUNT_EN.
module perf_readout #(
  parameter int unsigned WATCHDOG = 100000,
  parameter logic [7:0]  HDR_TAG  = 8'hC5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        isHalt,
  input  logic        W_v,
  input  logic [15:0] numIns,
  input  logic        rd_req,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_CYC_LO = 3'd2;
  localparam logic [2:0] S_CYC_HI = 3'd3;
  localparam logic [2:0] S_INS_LO = 3'd4;
  localparam logic [2:0] S_INS_HI = 3'd5;
  localparam logic [2:0] S_STL_LO = 3'd6;
  localparam logic [2:0] S_STL_HI = 3'd7;

`ifdef PERF_STALL_COUNT_EN
  localparam logic [2:0] S_FINAL = S_STL_HI;
  localparam logic       STL_BIT = 1'b1;
`else
  localparam logic [2:0] S_FINAL = S_INS_HI;
  localparam logic       STL_BIT = 1'b0;
`endif

  logic [2:0]  state, nxt;
  logic [31:0] cyc, ins, cyc_nx, ins_nx, snap_cyc, snap_ins;
  logic [32:0] ins_sum;
  logic        wd_fired, pend_halt, pend_wd;
  logic        run, halt_rise, wd_hit, hs, accept, f_halt, f_wd, fire;
  logic [15:0] nxt_word;

`ifdef PERF_STALL_COUNT_EN
  logic [31:0] stl, stl_nx, snap_stl;
`endif

  assign out_valid = (state != S_IDLE);
  assign busy      = (state != S_IDLE);

  // Counters saturate rather than wrap so an overlong run still reads as "huge".
  always_comb begin
    run     = !halted;
    cyc_nx  = (run && cyc != 32'hFFFF_FFFF) ? cyc + 32'd1 : cyc;
    ins_sum = {1'b0, ins} + {17'b0, numIns};
    ins_nx  = (run && W_v) ? (ins_sum[32] ? 32'hFFFF_FFFF : ins_sum[31:0]) : ins;
`ifdef PERF_STALL_COUNT_EN
    stl_nx  = (run && !W_v && stl != 32'hFFFF_FFFF) ? stl + 32'd1 : stl;
`endif
    halt_rise = isHalt && !halted;
    wd_hit    = (WATCHDOG != 0) && !wd_fired && (cyc_nx == WATCHDOG);
    hs        = out_valid && out_ready;
    // The out_last handshake doubles as an IDLE cycle so frames can run back to back.
    accept    = (state == S_IDLE) || (hs && state == S_FINAL);
    f_halt    = halt_rise || pend_halt;
    f_wd      = wd_hit || pend_wd;
    fire      = accept && (f_halt || f_wd || rd_req);
  end

  always_comb begin
    nxt      = S_IDLE;
    nxt_word = 16'h0;
    case (state)
      S_HDR:    nxt = S_CYC_LO;
      S_CYC_LO: nxt = S_CYC_HI;
      S_CYC_HI: nxt = S_INS_LO;
      S_INS_LO: nxt = S_INS_HI;
`ifdef PERF_STALL_COUNT_EN
      S_INS_HI: nxt = S_STL_LO;
      S_STL_LO: nxt = S_STL_HI;
`endif
      default:  nxt = S_IDLE;
    endcase
    case (nxt)
      S_CYC_LO: nxt_word = snap_cyc[15:0];
      S_CYC_HI: nxt_word = snap_cyc[31:16];
      S_INS_LO: nxt_word = snap_ins[15:0];
      S_INS_HI: nxt_word = snap_ins[31:16];
`ifdef PERF_STALL_COUNT_EN
      S_STL_LO: nxt_word = snap_stl[15:0];
      S_STL_HI: nxt_word = snap_stl[31:16];
`endif
      default:  nxt_word = 16'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= '0;
      ins       <= '0;
      halted    <= 1'b0;
      wd_fired  <= 1'b0;
      pend_halt <= 1'b0;
      pend_wd   <= 1'b0;
      state     <= S_IDLE;
      out_data  <= '0;
      out_last  <= 1'b0;
      snap_cyc  <= '0;
      snap_ins  <= '0;
`ifdef PERF_STALL_COUNT_EN
      stl       <= '0;
      snap_stl  <= '0;
`endif
    end else begin
      cyc      <= cyc_nx;
      ins      <= ins_nx;
      halted   <= halted | isHalt;
      wd_fired <= wd_fired | wd_hit;
`ifdef PERF_STALL_COUNT_EN
      stl      <= stl_nx;
`endif
      if (fire) begin
        snap_cyc  <= cyc_nx;
        snap_ins  <= ins_nx;
`ifdef PERF_STALL_COUNT_EN
        snap_stl  <= stl_nx;
`endif
        state     <= S_HDR;
        out_data  <= {HDR_TAG, 5'b0, STL_BIT, f_wd, f_halt};
        out_last  <= 1'b0;
        pend_halt <= 1'b0;
        pend_wd   <= 1'b0;
      end else begin
        if (hs) begin
          state    <= nxt;
          out_data <= nxt_word;
          out_last <= (nxt == S_FINAL);
        end
        // Host requests mid-frame are dropped; halt/watchdog wait for the frame to end.
        if (!accept) begin
          pend_halt <= pend_halt | halt_rise;
          pend_wd   <= pend_wd | wd_hit;
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_readout.sv
// Directed bench for perf_readout: host/halt/watchdog frames, backpressure, back-to-back, mid-frame reset.
module tb_perf_readout;

`ifdef PERF_STALL_COUNT_EN
  localparam int          NW = 7;
  localparam logic [15:0] SB = 16'h0004;
`else
  localparam int          NW = 5;
  localparam logic [15:0] SB = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n, isHalt, W_v, rd_req, out_ready;
  logic [15:0] numIns;
  logic        out_valid, out_last, busy, halted;
  logic [15:0] out_data;
  logic        wd_isHalt = 1'b0, wd_rd_req = 1'b0;
  logic        wd_valid, wd_last, wd_busy, wd_halted;
  logic [15:0] wd_data;

  int checks = 0, errors = 0;
  logic [15:0] fw [8];
  logic        fl [8];
  int          fn;

  always #5 clk = ~clk;

  perf_readout #(.WATCHDOG(0), .HDR_TAG(8'hC5)) u_dut (
    .clk(clk), .rst_n(rst_n), .isHalt(isHalt), .W_v(W_v), .numIns(numIns),
    .rd_req(rd_req), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .busy(busy), .halted(halted)
  );

  perf_readout #(.WATCHDOG(20), .HDR_TAG(8'hC5)) u_wd (
    .clk(clk), .rst_n(rst_n), .isHalt(wd_isHalt), .W_v(W_v), .numIns(numIns),
    .rd_req(wd_rd_req), .out_ready(out_ready), .out_valid(wd_valid),
    .out_data(wd_data), .out_last(wd_last), .busy(wd_busy), .halted(wd_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Collect one frame from u_dut, optionally toggling out_ready every cycle.
  task automatic collect(input bit toggle, input int budget);
    bit          done = 0, stalled = 0;
    logic [15:0] pd = '0;
    logic        pl = 1'b0;
    int          cnt = 0;
    fn = 0;
    while (!done && cnt < budget) begin
      if (stalled) begin
        chk("hold_data", 32'(out_data), 32'(pd));
        chk("hold_last", 32'(out_last), 32'(pl));
      end
      if (out_valid && out_ready) begin
        if (fn < 8) begin
          fw[fn] = out_data;
          fl[fn] = out_last;
        end
        fn++;
        done    = out_last;
        stalled = 0;
      end else begin
        stalled = out_valid;
        pd      = out_data;
        pl      = out_last;
      end
      @(negedge clk);
      cnt++;
      if (toggle) out_ready = ~out_ready;
    end
    chk("frame_done", 32'(done), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] hdr, input logic [31:0] c,
                             input logic [31:0] i, input logic [31:0] s);
    chk({tag, "_words"}, 32'(fn), 32'(NW));
    chk({tag, "_hdr"}, 32'(fw[0]), 32'(hdr));
    chk({tag, "_cyc_lo"}, 32'(fw[1]), 32'(c[15:0]));
    chk({tag, "_cyc_hi"}, 32'(fw[2]), 32'(c[31:16]));
    chk({tag, "_ins_lo"}, 32'(fw[3]), 32'(i[15:0]));
    chk({tag, "_ins_hi"}, 32'(fw[4]), 32'(i[31:16]));
`ifdef PERF_STALL_COUNT_EN
    chk({tag, "_stl_lo"}, 32'(fw[5]), 32'(s[15:0]));
    chk({tag, "_stl_hi"}, 32'(fw[6]), 32'(s[31:16]));
`else
    if (s != s) chk({tag, "_stl"}, s, 32'd0);
`endif
    for (int k = 0; k < NW; k++)
      chk({tag, "_last"}, 32'(fl[k]), 32'(k == NW - 1));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int wn, wf;
    logic [15:0] ww [8];

    rst_n = 1'b0; isHalt = 1'b0; W_v = 1'b0; numIns = '0; rd_req = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);

    // Host request after 10 retiring cycles: cyc 11, ins 20, one stall cycle.
    rst_n = 1'b1; W_v = 1'b1; numIns = 16'd2;
    repeat (10) @(negedge clk);
    W_v = 1'b0; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    collect(0, 20);
    check_frame("t1", 16'hC500 | SB, 32'd11, 32'd20, 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);

    // Halt at cycle 50 with 3 retiring in the halt cycle.
    reset_pulse();
    W_v = 1'b1; numIns = 16'd1;
    repeat (50) @(negedge clk);
    numIns = 16'd3; isHalt = 1'b1;
    @(negedge clk);
    numIns = 16'd1;
    chk("t2_halted", 32'(halted), 32'd1);
    collect(0, 20);
    check_frame("t2", 16'hC501 | SB, 32'd51, 32'd53, 32'd0);

    // Later host read with backpressure: counts frozen, words held while stalled.
    repeat (5) @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0; out_ready = 1'b0;
    collect(1, 40);
    out_ready = 1'b1;
    check_frame("t3", 16'hC500 | SB, 32'd51, 32'd53, 32'd0);

    // Halt during a host frame: that frame unaltered, halt frame follows at once.
    isHalt = 1'b0; W_v = 1'b0;
    reset_pulse();
    W_v = 1'b1; numIns = 16'd1;
    repeat (5) @(negedge clk);
    W_v = 1'b0; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0; isHalt = 1'b1;
    collect(0, 20);
    check_frame("t5a", 16'hC500 | SB, 32'd6, 32'd5, 32'd1);
    chk("t5_back2back", 32'(out_valid), 32'd1);
    collect(0, 20);
    check_frame("t5b", 16'hC501 | SB, 32'd7, 32'd5, 32'd2);

    // Reset while parked on CYC_HI.
    isHalt = 1'b0;
    reset_pulse();
    repeat (3) @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    chk("t6_cychi_valid", 32'(out_valid), 32'd1);
    chk("t6_cychi_last", 32'(out_last), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    collect(0, 20);
    check_frame("t6", 16'hC500 | SB, 32'd4, 32'd0, 32'd4);

    // Watchdog instance: exactly one frame at cyc 20 within 200 cycles.
    reset_pulse();
    W_v = 1'b0;
    wn = 0; wf = 0;
    for (int k = 0; k < 8; k++) ww[k] = 16'hFFFF;
    for (int c = 0; c < 200; c++) begin
      if (wd_valid && out_ready) begin
        if (wn < 8) ww[wn] = wd_data;
        wn++;
        if (wd_last) wf++;
      end
      @(negedge clk);
    end
    chk("wd_frames", 32'(wf), 32'd1);
    chk("wd_words", 32'(wn), 32'(NW));
    chk("wd_hdr", 32'(ww[0]), 32'(16'hC502 | SB));
    chk("wd_cyc_lo", 32'(ww[1]), 32'd20);
    chk("wd_cyc_hi", 32'(ww[2]), 32'd0);
    chk("wd_ins_lo", 32'(ww[3]), 32'd0);
`ifdef PERF_STALL_COUNT_EN
    chk("wd_stl_lo", 32'(ww[5]), 32'd20);
`endif
    chk("wd0_quiet", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
